uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default rates, divider helpers.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BR       = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Clock cycles per bit on the line.
  function automatic int baud_div(input int clk_freq, input int br);
    return clk_freq / br;
  endfunction

  // Clock cycles from the start edge to the middle of the start bit.
  function automatic int half_div(input int clk_freq, input int br);
    return baud_div(clk_freq, br) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side consumer handshake: the receiver is master, the consumer is slave.
interface uart_rx_if #(
  parameter int READ_WIDTH = 8
);

  logic [READ_WIDTH-1:0] read_data;
  logic                  read_vld;
  logic                  read_rdy;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output read_data, read_vld, parity_err, frame_err, overrun,
    input  read_rdy
  );

  modport slave (
    input  read_data, read_vld, parity_err, frame_err, overrun,
    output read_rdy
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts while enabled, ticks when the count equals the terminal value.
module uart_baud_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q;

  // Counter register; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = enable_i && (cnt_q == term_i);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, samples mid-bit, checks even parity and stop bit,
// and presents each word through a valid/ready handshake with overrun detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BR         = DEF_BR,
  parameter int READ_WIDTH = 8,
  parameter int CHEAK      = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master rd
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BR);
  localparam int HALF_DIV = half_div(CLK_FREQ, BR);
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int BW       = $clog2(READ_WIDTH);
  localparam bit PAR_EN   = (CHEAK != 0);

  localparam logic [CW-1:0] TERM_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] TERM_HALF = CW'(HALF_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(READ_WIDTH - 1);

  uart_state_e state_q, state_d;

  logic                  sync1_q, rx_s_q, rx_prev_q;
  logic                  start_edge;
  logic                  cnt_clr, cnt_en, tick;
  logic [CW-1:0]         cnt_term;
  logic                  shift_en, par_en, word_done, stop_bad;
  logic [READ_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  par_q;
  logic [READ_WIDTH-1:0] read_data_q;
  logic                  read_vld_q, parity_err_q, frame_err_q, overrun_q;

  // Two-flop synchronizer for rx plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make these flops a true shift chain regardless of evaluation order.
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge = rx_prev_q && !rx_s_q;

  uart_baud_cnt #(.WIDTH(CW)) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clr),
    .enable_i (cnt_en),
    .term_i   (cnt_term),
    .tick_o   (tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; every transition except IDLE/BREAK waits for a baud tick.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_edge) state_d = ST_START;
      ST_START:  if (tick) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && (bit_cnt_q == LAST_BIT)) state_d = PAR_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: baud counter control and per-state sample strobes.
  always_comb begin
    cnt_en    = (state_q != ST_IDLE) && (state_q != ST_BREAK);
    cnt_clr   = !cnt_en || tick;
    cnt_term  = (state_q == ST_START) ? TERM_HALF : TERM_FULL;
    shift_en  = (state_q == ST_DATA)   && tick;
    par_en    = (state_q == ST_PARITY) && tick;
    word_done = (state_q == ST_STOP)   && tick && rx_s_q;
    stop_bad  = (state_q == ST_STOP)   && tick && !rx_s_q;
  end

  // Receive datapath: LSB-first shift register, bit counter, parity result.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
    end else begin
      if (shift_en) begin
        shift_q   <= {rx_s_q, shift_q[READ_WIDTH-1:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end else if (state_q != ST_DATA) begin
        bit_cnt_q <= '0;
      end
      if (par_en) par_q <= (^shift_q) ^ rx_s_q;
    end
  end

  // Output holding register with valid/ready handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q  <= '0;
      read_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (word_done) begin
        if (!read_vld_q || rd.read_rdy) begin
          read_data_q  <= shift_q;
          parity_err_q <= PAR_EN ? par_q : 1'b0;
          read_vld_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (read_vld_q && rd.read_rdy) begin
        read_vld_q <= 1'b0;
      end
    end
  end

  assign rd.read_data  = read_data_q;
  assign rd.read_vld   = read_vld_q;
  assign rd.parity_err = parity_err_q;
  assign rd.frame_err  = frame_err_q;
  assign rd.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 10 clocks per bit; one receiver
// expects an even parity bit, a second one receives frames without parity.
module tb_uart_rx;

  localparam int BIT = 10;

  logic clk = 1'b0;
  logic rst;
  logic rx1, rx0;

  int n_checks = 0;
  int n_fail   = 0;

  int       vld1_cnt = 0, ferr1_cnt = 0, ovr1_cnt = 0, vld0_cnt = 0;
  logic [7:0] last_data1, last_data0;
  logic       last_perr1, last_perr0;

  uart_rx_if #(.READ_WIDTH(8)) bus1 ();
  uart_rx_if #(.READ_WIDTH(8)) bus0 ();

  uart_rx #(.CLK_FREQ(1000000), .BR(100000), .READ_WIDTH(8), .CHEAK(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .rx  (rx1),
    .rd  (bus1)
  );

  uart_rx #(.CLK_FREQ(1000000), .BR(100000), .READ_WIDTH(8), .CHEAK(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .rx  (rx0),
    .rd  (bus0)
  );

  always #5 clk = ~clk;

  // Observe outputs mid-cycle: count valid cycles and error pulses, capture words.
  always @(negedge clk) begin
    if (bus1.read_vld) begin
      vld1_cnt++;
      last_data1 = bus1.read_data;
      last_perr1 = bus1.parity_err;
    end
    if (bus1.frame_err) ferr1_cnt++;
    if (bus1.overrun)   ovr1_cnt++;
    if (bus0.read_vld) begin
      vld0_cnt++;
      last_data0 = bus0.read_data;
      last_perr0 = bus0.parity_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rx1 = v;
    else       rx0 = v;
  endtask

  // Drives start, data (LSB first) and optional parity; leaves the line at the stop level.
  task automatic send_frame(input bit which, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(par);
    foreach (bits[i]) begin
      set_line(which, bits[i]);
      tick(BIT);
    end
    set_line(which, stop);
  endtask

  // Reference: even parity is violated when the total count of ones is odd.
  function automatic logic exp_perr(input logic [7:0] d, input logic par);
    return (($countones({d, par}) % 2) == 1);
  endfunction

  task automatic xfer1(input logic [7:0] d, input logic par, input string tag);
    int base;
    base = vld1_cnt;
    send_frame(1'b1, d, 1'b1, par, 1'b1);
    tick(14);
    check({tag, "_vld_cycles"}, vld1_cnt - base, 1);
    check({tag, "_data"}, last_data1, d);
    check({tag, "_perr"}, last_perr1, exp_perr(d, par));
  endtask

  task automatic xfer0(input logic [7:0] d, input string tag);
    int base;
    base = vld0_cnt;
    send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
    tick(14);
    check({tag, "_vld_cycles"}, vld0_cnt - base, 1);
    check({tag, "_data"}, last_data0, d);
    check({tag, "_perr"}, last_perr0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_v, b_f, b_o;
    logic [7:0] d;
    logic       p;

    rst = 1'b1;
    rx1 = 1'b1;
    rx0 = 1'b1;
    bus1.read_rdy = 1'b1;
    bus0.read_rdy = 1'b1;
    tick(4);
    check("rst_data", bus1.read_data, 0);
    check("rst_vld", bus1.read_vld, 0);
    check("rst_perr", bus1.parity_err, 0);
    check("rst_ferr", bus1.frame_err, 0);
    check("rst_ovr", bus1.overrun, 0);
    rst = 1'b0;
    tick(5);

    // 0xA5 with correct parity: valid rises exactly one cycle after the stop sample.
    b_v = vld1_cnt;
    send_frame(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    tick(7);
    check("a5_vld_before", bus1.read_vld, 0);
    tick(1);
    check("a5_vld_rise", bus1.read_vld, 1);
    check("a5_data", bus1.read_data, 8'hA5);
    check("a5_perr", bus1.parity_err, 0);
    tick(1);
    check("a5_vld_fall", bus1.read_vld, 0);
    tick(5);
    check("a5_vld_cycles", vld1_cnt - b_v, 1);

    // Wrong parity bit, then the same word on the receiver without parity.
    xfer1(8'h3C, 1'b1, "p3c");
    xfer0(8'h3C, "n3c");

    // Start-bit glitch: nothing happens, next frame is clean.
    b_v = vld1_cnt;
    b_f = ferr1_cnt;
    rx1 = 1'b0;
    tick(3);
    rx1 = 1'b1;
    tick(20);
    check("glitch_vld", vld1_cnt - b_v, 0);
    check("glitch_ferr", ferr1_cnt - b_f, 0);
    xfer1(8'h55, 1'b0, "g55");

    // Low stop bit with a 30-cycle break.
    b_v = vld1_cnt;
    b_f = ferr1_cnt;
    send_frame(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    tick(30);
    rx1 = 1'b1;
    tick(20);
    check("brk_ferr_cycles", ferr1_cnt - b_f, 1);
    check("brk_vld", vld1_cnt - b_v, 0);
    xfer1(8'h34, 1'b1, "f34");

    // Overrun: second word dropped while the first is held.
    bus1.read_rdy = 1'b0;
    b_o = ovr1_cnt;
    send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    tick(BIT);
    send_frame(1'b1, 8'h02, 1'b1, 1'b1, 1'b1);
    tick(14);
    check("ovr_vld", bus1.read_vld, 1);
    check("ovr_data_held", bus1.read_data, 8'h01);
    check("ovr_pulses", ovr1_cnt - b_o, 1);

    // Ready in the completion cycle: new word loads, no overrun.
    b_o = ovr1_cnt;
    send_frame(1'b1, 8'h02, 1'b1, 1'b1, 1'b1);
    tick(7);
    bus1.read_rdy = 1'b1;
    tick(1);
    check("swap_vld", bus1.read_vld, 1);
    check("swap_data", bus1.read_data, 8'h02);
    bus1.read_rdy = 1'b0;
    tick(1);
    check("swap_vld_hold", bus1.read_vld, 1);
    check("swap_data_hold", bus1.read_data, 8'h02);
    check("swap_perr", bus1.parity_err, 0);
    check("swap_no_ovr", ovr1_cnt - b_o, 0);
    tick(5);

    // Reset during data bit 4 while a word is still held.
    b_f = ferr1_cnt;
    b_o = ovr1_cnt;
    rx1 = 1'b0;
    tick(5 * BIT);
    rx1 = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("mid_rst_vld", bus1.read_vld, 0);
    check("mid_rst_data", bus1.read_data, 0);
    check("mid_rst_perr", bus1.parity_err, 0);
    tick(2);
    rst = 1'b0;
    b_v = vld1_cnt;
    tick(60);
    check("mid_rst_no_vld", vld1_cnt - b_v, 0);
    check("mid_rst_no_ferr", ferr1_cnt - b_f, 0);
    check("mid_rst_no_ovr", ovr1_cnt - b_o, 0);
    bus1.read_rdy = 1'b1;
    xfer1(8'hFF, 1'b0, "rst_ff");

    // Random words with random (right or wrong) parity bits.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      xfer1(d, p, "rnd_par");
    end
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      xfer0(d, "rnd_nopar");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
